// File: rtl/poly_mult_seq.sv
// poly_mult_seq: job sequencer between the register block and the polynomial
// multiplier core. Buffers operands, issues them to the core one at a time over
// a load/busy handshake, stores results, and can interleave LFSR-chosen dummy
// multiplications to mask the real operation count and positions.
module poly_mult_seq #(
  parameter int          pDATA_WIDTH = 128,
  parameter int          pKEY_WIDTH  = 128,
  parameter int          pMAX_OPS    = 8,
  parameter int          pIDX_W      = 3,
  parameter logic [15:0] pLFSR_SEED  = 16'hACE1,
  parameter int          pTIMEOUT    = 1023
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en_i,
  input  logic [pDATA_WIDTH-1:0] wr_data_i,
  input  logic                   clr_i,
  input  logic                   start_i,
  input  logic                   dummy_en_i,
  input  logic [pKEY_WIDTH-1:0]  key_i,
  input  logic [pIDX_W-1:0]      rd_idx_i,
  output logic [pDATA_WIDTH-1:0] rd_data_o,
  output logic [pIDX_W:0]        count_o,
  output logic                   full_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [7:0]             ops_issued_o,
  output logic                   trig_o,
  output logic                   core_load_o,
  output logic [pKEY_WIDTH-1:0]  core_key_o,
  output logic [pDATA_WIDTH-1:0] core_data_o,
  input  logic [pDATA_WIDTH-1:0] core_data_i,
  input  logic                   core_busy_i
);

  localparam int              TMO_W   = $clog2(pTIMEOUT + 1);
  localparam logic [pIDX_W:0] MAX_CNT = (pIDX_W + 1)'(pMAX_OPS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(pTIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_CAPTURE, S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [pIDX_W:0]        count_q;
  logic [pIDX_W:0]        n_q;
  logic [pIDX_W:0]        r_q;
  logic [1:0]             d_q;
  logic [15:0]            lfsr_q;
  logic [pKEY_WIDTH-1:0]  key_q;
  logic                   dummy_en_q;
  logic                   err_q;
  logic [7:0]             ops_q;
  logic [pDATA_WIDTH-1:0] data_q;
  logic [TMO_W-1:0]       tmo_q;

  logic [pDATA_WIDTH-1:0] op_buf  [pMAX_OPS];
  logic [pDATA_WIDTH-1:0] res_buf [pMAX_OPS];

  logic                   is_dummy;
  logic                   tmo_hit;
  logic                   wait_tmo;
  logic                   wr_ok;
  logic [pIDX_W:0]        r_nxt;
  logic [15:0]            lfsr_nxt;
  logic [pDATA_WIDTH-1:0] issue_data;

  // A pending dummy count means the op in flight is a dummy, not real op r.
  assign is_dummy = (d_q != 2'd0);
  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign wait_tmo = tmo_hit &&
                    (((state_q == S_WAIT_HI) && !core_busy_i) ||
                     ((state_q == S_WAIT_LO) &&  core_busy_i));
  assign wr_ok    = (state_q == S_IDLE) && !clr_i && wr_en_i && (count_q < MAX_CNT);
  assign r_nxt    = r_q + 1'b1;
  // Fibonacci LFSR, x^16+x^14+x^13+x^11: shift left, feedback into bit 0.
  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign issue_data = is_dummy ? {(pDATA_WIDTH / 16){lfsr_q}}
                               : op_buf[r_q[pIDX_W-1:0]];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; an observed busy edge wins over a simultaneous timeout.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_i) state_d = (count_q == '0) ? S_FIN : S_PICK;
      S_PICK:    state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT_HI;
      S_WAIT_HI: if (core_busy_i) state_d = S_WAIT_LO;
                 else if (tmo_hit) state_d = S_FIN;
      S_WAIT_LO: if (!core_busy_i) state_d = S_CAPTURE;
                 else if (tmo_hit) state_d = S_FIN;
      S_CAPTURE: if (is_dummy)       state_d = S_ISSUE;
                 else if (r_nxt < n_q) state_d = S_PICK;
                 else                state_d = S_FIN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state so reset drops them without waiting for a clock.
  always_comb begin
    core_load_o = (state_q == S_ISSUE);
    done_o      = (state_q == S_FIN);
    // An empty job passes through FIN without ever looking busy.
    busy_o      = (state_q != S_IDLE) && !((state_q == S_FIN) && (n_q == '0));
    // PICK with r>0 sits between real ops, so the trigger window stays continuous.
    trig_o      = (state_q == S_ISSUE) || (state_q == S_WAIT_HI) ||
                  (state_q == S_WAIT_LO) || (state_q == S_CAPTURE) ||
                  ((state_q == S_PICK) && (r_q != '0));
    core_data_o = (state_q == S_ISSUE) ? issue_data : data_q;
  end

  assign count_o      = count_q;
  assign full_o       = (count_q == MAX_CNT);
  assign err_o        = err_q;
  assign ops_issued_o = ops_q;
  assign core_key_o   = key_q;
  assign rd_data_o    = res_buf[rd_idx_i];

  // Job control datapath: operand count, job latches, LFSR, counters, timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q    <= '0;
      n_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      lfsr_q     <= pLFSR_SEED;
      key_q      <= '0;
      dummy_en_q <= 1'b0;
      err_q      <= 1'b0;
      ops_q      <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (state_q == S_IDLE) begin
        if (clr_i)      count_q <= '0;
        else if (wr_ok) count_q <= count_q + 1'b1;
        if (start_i) begin
          key_q      <= key_i;
          dummy_en_q <= dummy_en_i;
          n_q        <= count_q;
          err_q      <= 1'b0;
          ops_q      <= '0;
          r_q        <= '0;
          d_q        <= '0;
        end
      end

      if (state_q == S_PICK) d_q <= dummy_en_q ? lfsr_q[1:0] : 2'd0;

      if (state_q == S_ISSUE) begin
        data_q <= issue_data;
        lfsr_q <= lfsr_nxt;
        if (ops_q != 8'hFF) ops_q <= ops_q + 8'd1;
      end

      if (wait_tmo) err_q <= 1'b1;

      if (state_q == S_CAPTURE) begin
        if (is_dummy) d_q <= d_q - 2'd1;
        else          r_q <= r_nxt;
      end

      if (state_q == S_FIN) count_q <= '0;

      // Restart the wait counter whenever the state changes.
      if (state_d != state_q) tmo_q <= '0;
      else if ((state_q == S_WAIT_HI) || (state_q == S_WAIT_LO)) tmo_q <= tmo_q + 1'b1;
    end
  end

  // Operand and result storage.
  // NOTE: memories carry no reset; their contents are don't-care until written,
  // and leaving reset off lets them map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (wr_ok) op_buf[count_q[pIDX_W-1:0]] <= wr_data_i;
    if ((state_q == S_CAPTURE) && !is_dummy) res_buf[r_q[pIDX_W-1:0]] <= core_data_i;
  end

endmodule
